// File: rtl/intr_ctrl.sv
// Eight-source priority interrupt controller feeding the reg_intr vector lookup.
// Optional IRQ_SYNC_EN: two-flop synchronizer on irq_in (adds 2 cycles of request latency).
`timescale 1ns/1ps
module intr_ctrl #(
    parameter logic [7:0] MASK_RST  = 8'hFF,
    parameter bit         EDGE_TRIG = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic       mask_we,
    input  logic [7:0] mask_data,
    input  logic       intr_ack,
    input  logic       intr_ret,
    output logic       intr_req,
    output logic [7:0] intr_selec,
    output logic [7:0] pending,
    output logic [7:0] mask
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e     state_q;
    logic       req_q;
    logic [7:0] selec_q;
    logic [7:0] mask_q;
    logic [7:0] pending_q, pending_d;
    logic [7:0] irq_prev_q;
    logic [7:0] irq_s;
    logic [7:0] active;
    logic [7:0] lowest;
    logic [7:0] ack_clr;

`ifdef IRQ_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    // Reset to all-ones so lines already high at reset release look "old".
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 8'hFF;
            sync2_q <= 8'hFF;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        active    = pending_q & mask_q;
        lowest    = active & (~active + 8'd1);
        ack_clr   = 8'h00;
        pending_d = pending_q;
        if (state_q == REQ && intr_ack) begin
            ack_clr = selec_q;
        end
        if (EDGE_TRIG) begin
            // A fresh edge is OR-ed in after the ack clear, so a same-cycle set wins.
            pending_d = (pending_q & ~ack_clr) | (irq_s & ~irq_prev_q);
        end else begin
            pending_d = irq_s;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= 8'h00;
            irq_prev_q <= 8'hFF;
            mask_q     <= MASK_RST;
        end else begin
            pending_q  <= pending_d;
            irq_prev_q <= irq_s;
            if (mask_we) begin
                mask_q <= mask_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            selec_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (active != 8'h00) begin
                        selec_q <= lowest;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end else begin
                        selec_q <= 8'h00;
                        req_q   <= 1'b0;
                    end
                end
                REQ: begin
                    if (intr_ack) begin
                        req_q   <= 1'b0;
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    // Vector stays valid for the whole ISR; cleared only on return.
                    if (intr_ret) begin
                        selec_q <= 8'h00;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    selec_q <= 8'h00;
                end
            endcase
        end
    end

    assign intr_req   = req_q;
    assign intr_selec = selec_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl in its default build (edge mode, no synchronizer).
`timescale 1ns/1ps
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_data;
    logic       intr_ack;
    logic       intr_ret;
    logic       intr_req;
    logic [7:0] intr_selec;
    logic [7:0] pending;
    logic [7:0] mask;

    int vectors     = 0;
    int miscompares = 0;

    intr_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_data  (mask_data),
        .intr_ack   (intr_ack),
        .intr_ret   (intr_ret),
        .intr_req   (intr_req),
        .intr_selec (intr_selec),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_in = 8'h00; mask_we = 1'b0; mask_data = 8'h00;
        intr_ack = 1'b0; intr_ret = 1'b0;
        tick(); tick();
        vectors++;
        if ({intr_req, intr_selec, pending, mask} !== {1'b0, 8'h00, 8'h00, 8'hFF}) begin
            miscompares++;
            $display("FAIL reset_values: req/selec/pending/mask got %b/%h/%h/%h want 0/00/00/ff",
                     intr_req, intr_selec, pending, mask);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_pulse();
        irq_in = 8'h04; tick();
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h00, 8'h04}) begin
            miscompares++;
            $display("FAIL t1_pending: req/selec/pending got %b/%h/%h want 0/00/04", intr_req, intr_selec, pending);
        end
        irq_in = 8'h00; tick();
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b1, 8'h04, 8'h04}) begin
            miscompares++;
            $display("FAIL t1_request: req/selec/pending got %b/%h/%h want 1/04/04", intr_req, intr_selec, pending);
        end
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h04, 8'h00}) begin
            miscompares++;
            $display("FAIL t1_ack: req/selec/pending got %b/%h/%h want 0/04/00", intr_req, intr_selec, pending);
        end
        intr_ret = 1'b1; tick(); intr_ret = 1'b0;
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL t1_ret: req/selec/pending got %b/%h/%h want 0/00/00", intr_req, intr_selec, pending);
        end
    endtask

    task automatic test_priority();
        irq_in = 8'h82; tick();
        irq_in = 8'h00; tick();
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b1, 8'h02, 8'h82}) begin
            miscompares++;
            $display("FAIL t2_first: req/selec/pending got %b/%h/%h want 1/02/82", intr_req, intr_selec, pending);
        end
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        vectors++;
        if ({intr_req, pending} !== {1'b0, 8'h80}) begin
            miscompares++;
            $display("FAIL t2_ack: req/pending got %b/%h want 0/80", intr_req, pending);
        end
        intr_ret = 1'b1; tick(); intr_ret = 1'b0;
        vectors++;
        if ({intr_req, intr_selec} !== {1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL t2_idle_gap: req/selec got %b/%h want 0/00", intr_req, intr_selec);
        end
        tick();
        vectors++;
        if ({intr_req, intr_selec} !== {1'b1, 8'h80}) begin
            miscompares++;
            $display("FAIL t2_second: req/selec got %b/%h want 1/80", intr_req, intr_selec);
        end
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        intr_ret = 1'b1; tick(); intr_ret = 1'b0;
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL t2_drain: req/selec/pending got %b/%h/%h want 0/00/00", intr_req, intr_selec, pending);
        end
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_data = 8'hFE; tick(); mask_we = 1'b0;
        vectors++;
        if (mask !== 8'hFE) begin
            miscompares++;
            $display("FAIL t3_mask_write: mask got %h want fe", mask);
        end
        irq_in = 8'h01; tick();
        irq_in = 8'h00; tick(); tick();
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h00, 8'h01}) begin
            miscompares++;
            $display("FAIL t3_masked: req/selec/pending got %b/%h/%h want 0/00/01", intr_req, intr_selec, pending);
        end
        mask_we = 1'b1; mask_data = 8'hFF; tick(); mask_we = 1'b0;
        tick();
        vectors++;
        if ({intr_req, intr_selec, mask} !== {1'b1, 8'h01, 8'hFF}) begin
            miscompares++;
            $display("FAIL t3_unmasked: req/selec/mask got %b/%h/%h want 1/01/ff", intr_req, intr_selec, mask);
        end
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        intr_ret = 1'b1; tick(); intr_ret = 1'b0;
    endtask

    task automatic test_no_nesting();
        irq_in = 8'h08; tick();
        irq_in = 8'h00; tick();
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        irq_in = 8'h01; tick();
        irq_in = 8'h00; tick(); tick();
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h08, 8'h01}) begin
            miscompares++;
            $display("FAIL t4_in_service: req/selec/pending got %b/%h/%h want 0/08/01", intr_req, intr_selec, pending);
        end
        intr_ret = 1'b1; tick(); intr_ret = 1'b0;
        tick();
        vectors++;
        if ({intr_req, intr_selec} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL t4_queued: req/selec got %b/%h want 1/01", intr_req, intr_selec);
        end
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        intr_ret = 1'b1; tick(); intr_ret = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        mask_we = 1'b1; mask_data = 8'hF0; tick(); mask_we = 1'b0;
        irq_in = 8'h30; tick();
        irq_in = 8'h00; tick();
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b1, 8'h10, 8'h30}) begin
            miscompares++;
            $display("FAIL t5_in_req: req/selec/pending got %b/%h/%h want 1/10/30", intr_req, intr_selec, pending);
        end
        reset = 1'b1; irq_in = 8'h01; tick();
        vectors++;
        if ({intr_req, intr_selec, pending, mask} !== {1'b0, 8'h00, 8'h00, 8'hFF}) begin
            miscompares++;
            $display("FAIL t5_reset: req/selec/pending/mask got %b/%h/%h/%h want 0/00/00/ff",
                     intr_req, intr_selec, pending, mask);
        end
        reset = 1'b0; tick(); tick(); tick();
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL t5_held_line: req/selec/pending got %b/%h/%h want 0/00/00", intr_req, intr_selec, pending);
        end
        irq_in = 8'h00; tick();
    endtask

    task automatic test_back_to_back();
        irq_in = 8'h04; tick();
        irq_in = 8'h00; tick();
        irq_in = 8'h04; intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        irq_in = 8'h00;
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h04, 8'h04}) begin
            miscompares++;
            $display("FAIL t6_set_wins: req/selec/pending got %b/%h/%h want 0/04/04", intr_req, intr_selec, pending);
        end
        intr_ret = 1'b1; tick(); intr_ret = 1'b0;
        tick();
        vectors++;
        if ({intr_req, intr_selec} !== {1'b1, 8'h04}) begin
            miscompares++;
            $display("FAIL t6_reassert: req/selec got %b/%h want 1/04", intr_req, intr_selec);
        end
        // Ack and ret together while in REQ: only the ack applies.
        intr_ack = 1'b1; intr_ret = 1'b1; tick(); intr_ack = 1'b0; intr_ret = 1'b0;
        vectors++;
        if ({intr_req, intr_selec, pending} !== {1'b0, 8'h04, 8'h00}) begin
            miscompares++;
            $display("FAIL t6_ack_ret: req/selec/pending got %b/%h/%h want 0/04/00", intr_req, intr_selec, pending);
        end
        intr_ret = 1'b1; tick(); intr_ret = 1'b0;
        vectors++;
        if ({intr_req, intr_selec} !== {1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL t6_final_ret: req/selec got %b/%h want 0/00", intr_req, intr_selec);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_pulse();
        test_priority();
        test_mask();
        test_no_nesting();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller that sits directly upstream of the interrupt vector lookup (reg_intr) in the basic CPU.
- Captures eight external request lines, applies an enable mask and picks the highest-priority pending source (bit 0 highest).
- Drives the one-hot `intr_selec` bus consumed by the vector lookup.
- Runs a request/acknowledge/return handshake with the CPU control unit; no nesting.

Parameters:
- MASK_RST, 8'hFF, reset value of the enable mask.
- EDGE_TRIG, 1, 1 = rising-edge capture into sticky pending bits; 0 = level-sensitive (pending mirrors irq_in).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- irq_in  in  8  external interrupt lines, synchronous to clk unless IRQ_SYNC_EN
- mask_we  in  1  write strobe for the mask register
- mask_data  in  8  new mask value (1 = source enabled)
- intr_ack  in  1  CPU acknowledge: vector taken, ISR entered
- intr_ret  in  1  CPU return-from-interrupt strobe
- intr_req  out  1  interrupt request to control unit
- intr_selec  out  8  one-hot selected source, feeds vector lookup
- pending  out  8  raw pending register (status)
- mask  out  8  current mask register

Behaviour:
- Reset (sync, active-high) values:
  - intr_req=0, intr_selec=8'h00, pending=8'h00, mask=MASK_RST, state=IDLE.
  - irq_prev=8'hFF, so lines already high at reset release do not fire.
- Edge mode (EDGE_TRIG=1):
  - pending[i] set on the clock edge where irq_in[i]=1 and irq_prev[i]=0; irq_prev <= irq_in every cycle.
  - pending[i] cleared only by acknowledge of source i.
  - Set and clear of the same bit in the same cycle: set wins.
- Level mode (EDGE_TRIG=0): pending <= irq_in every cycle; ack does not clear it.
- Mask:
  - mask_we=1 loads mask_data at the next edge.
  - Masking never clears pending bits.
  - mask_we has no effect on a source already selected.
- FSM, state IDLE:
  - If (pending & mask) != 0, load intr_selec with the lowest set bit of (pending & mask), one-hot.
  - Same edge: set intr_req=1 and go to REQ. Otherwise intr_selec=0.
- FSM, state REQ:
  - intr_req and intr_selec held stable.
  - On intr_ack=1: intr_req<=0, clear pending bit for the selected source (edge mode), go to SERVICE.
  - intr_ret in REQ is ignored.
- FSM, state SERVICE:
  - intr_selec held, so the vector stays valid; intr_req=0.
  - New requests only accumulate in pending.
  - On intr_ret=1: intr_selec<=0, go to IDLE.
  - intr_ack in SERVICE is ignored.
- Latency:
  - irq_in rise sampled at edge n → pending set after edge n → intr_req and intr_selec valid after edge n+1.
  - After intr_ret at edge m, a queued request re-asserts intr_req after edge m+1, since IDLE is occupied one cycle.
- Simultaneous requests: lowest index served first. Others remain pending and are served in priority order on later passes through IDLE.
- intr_ack and intr_ret both high: act per current state only.
- Reset mid-operation (any state): immediate return to reset values at that edge. Pending requests are lost.
- intr_selec is always zero or exactly one-hot, so the vector lookup's default branch is never reached while intr_req=1.

Optional Feature:
- Macro: IRQ_SYNC_EN
- Defined: each irq_in bit passes through a two-flop synchronizer (reset to 1) before edge detect and level capture. Adds 2 cycles to request latency; irq_in may then be asynchronous.
- Undefined: irq_in is used directly, with latency as stated above.

Test Plan:
1. Reset, then pulse irq_in=8'h04 for 1 cycle → pending=8'h04 next cycle; following cycle intr_req=1 and intr_selec=8'h04. Ack → pending=8'h00, intr_req=0. Ret → intr_selec=8'h00.
2. irq_in rises 8'h00→8'h82 in one cycle → intr_selec=8'h02 first. After ack and ret, intr_selec=8'h80 with intr_req=1 two cycles after ret.
3. mask_we with mask_data=8'hFE, then pulse bit 0 → pending=8'h01, intr_req stays 0. Write mask 8'hFF → intr_req=1, intr_selec=8'h01.
4. During SERVICE of bit 3, pulse bit 0 → intr_req stays 0 and intr_selec stays 8'h08 until ret. Then intr_selec=8'h01.
5. Assert reset while in REQ with pending=8'h30 → next cycle intr_req=0, intr_selec=0, pending=0, mask=8'hFF. Hold irq_in=8'h01 across reset release → no request.
6. Same-cycle new edge on bit 2 and ack of bit 2 → pending[2]=1 after the edge; intr_req re-asserts after ret.
